fx2_stream_writer: RTL and testbench
====================================

Name: fx2_stream_writer

Overview:
Upstream feeder for the FX2 slave-FIFO IN endpoint on the USB stream clock domain. Takes a 16-bit valid/ready word stream from the TLU event path and drives the FX2 slave-FIFO write signals. Counts words per USB packet and commits short packets with PKTEND after an idle timeout or on disable. Replaces the free-running test counter feeding USB_STREAM_DATA.

Parameters:
PKT_WORDS, 256, words per full USB packet (512 bytes); power of two, 2..256
TIMEOUT, 1024, idle cycles in a partial packet before forced PKTEND; >=2
EP_ADDR, 2'b10, constant driven on USB_STREAM_FIFOADDR

Ports:
STREAM_CLK  in  1  stream clock; all logic on rising edge
STREAM_RST_N  in  1  asynchronous active-low reset
ENABLE  in  1  streaming enable, level
DATA  in  16  input word
DATA_VALID  in  1  DATA holds a word
DATA_READY  out  1  word accepted this cycle (combinational)
USB_STREAM_FLAGS_N  in  3  FX2 flags; bit 1 high = endpoint not full
USB_STREAM_FX2Rdy  in  1  FX2 firmware ready
USB_STREAM_FIFOADDR  out  2  endpoint select, = EP_ADDR
USB_STREAM_DATA  out  16  write data, = DATA (pass-through)
USB_STREAM_SLWR_n  out  1  write strobe, active low (combinational)
USB_STREAM_PKTEND_N  out  1  packet commit, active low (state-decoded)
USB_STREAM_SLOE_n  out  1  constant 1
USB_STREAM_SLRD_n  out  1  constant 1
WORD_COUNT  out  32  total words written, wraps
PKT_FILL  out  9  words in current partial packet

Behaviour:
- Reset (async, STREAM_RST_N=0): state IDLE; pkt_cnt=0; idle_cnt=0; WORD_COUNT=0. Outputs: SLWR_n=1, PKTEND_N=1, DATA_READY=0.
- nfull = USB_STREAM_FLAGS_N[1].
- accept = (state==WRITE) & ENABLE & DATA_VALID & nfull & USB_STREAM_FX2Rdy.
- SLWR_n = ~accept and DATA_READY = accept, both in the same cycle. No other write strobe exists.
- States: IDLE, WRITE, FLUSH, GAP.
- IDLE -> WRITE when ENABLE & FX2Rdy & nfull; otherwise stay.
- WRITE behaviour:
  - On accept: pkt_cnt = (pkt_cnt==PKT_WORDS-1) ? 0 : pkt_cnt+1. A full packet auto-commits in the FX2, so no PKTEND is issued. WORD_COUNT+1. idle_cnt=0.
  - No accept and pkt_cnt!=0: idle_cnt+1, saturating at TIMEOUT-1.
  - No accept and pkt_cnt==0: idle_cnt=0.
- WRITE exits, in priority order:
  - ENABLE=0 and pkt_cnt!=0 -> FLUSH.
  - ENABLE=0 and pkt_cnt==0 -> IDLE.
  - idle_cnt==TIMEOUT-1 and nfull and pkt_cnt!=0 and no accept this cycle -> FLUSH.
- Simultaneous accept and timeout: accept wins, idle_cnt clears, state stays WRITE.
- Full (nfull=0) in WRITE: SLWR_n held 1, DATA_READY=0, state held. A timeout that expires while full is deferred until nfull=1.
- FX2Rdy=0 in WRITE: writes blocked, same as full; state held.
- FLUSH: exactly one cycle. PKTEND_N=0, SLWR_n=1, DATA_READY=0. pkt_cnt=0 and idle_cnt=0. Next state GAP.
- GAP: one cycle, all strobes inactive (FX2 recovery). Next state IDLE.
- PKTEND_N is 0 only in FLUSH. PKTEND is never asserted with pkt_cnt==0, so no zero-length packets.
- PKT_FILL = pkt_cnt, zero-extended.
- WORD_COUNT wraps from 0xFFFFFFFF to 0.
- Reset mid-packet: state and counters clear immediately; no PKTEND is issued. Partial FX2 data is left to firmware.
- DATA and DATA_VALID must stay stable while DATA_VALID=1 and DATA_READY=0 (source obligation). The bench checks this.

Test Plan:
- Bench uses PKT_WORDS=4, TIMEOUT=8.
- Reset, then ENABLE=1, FX2Rdy=1, nfull=1, DATA_VALID=1 with DATA=0x0001..0x0008 -> 8 consecutive SLWR_n=0 cycles from WRITE entry, USB_STREAM_DATA equal to each word, PKTEND_N never 0, WORD_COUNT=8, PKT_FILL=0.
- Send 3 words, then DATA_VALID=0 -> PKT_FILL=3; after 8 idle cycles, one PKTEND_N=0 cycle, then GAP, then IDLE; PKT_FILL=0; WORD_COUNT=3.
- Send 2 words, drop nfull for 20 cycles -> no SLWR_n and no PKTEND while full; PKTEND_N=0 within 1 cycle of nfull returning to 1.
- Send 1 word, DATA_VALID=1 exactly on the cycle idle_cnt reaches 7 -> word accepted, no PKTEND, PKT_FILL=2.
- Send 2 words, deassert ENABLE -> FLUSH next cycle (PKTEND_N=0 once). Repeat with PKT_FILL=0 -> direct return to IDLE, PKTEND_N stays 1.
- Assert STREAM_RST_N=0 asynchronously mid-packet (PKT_FILL=2, SLWR_n=0) -> SLWR_n=1, PKTEND_N=1, WORD_COUNT=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fx2_stream_writer.sv
// fx2_stream_writer: valid/ready word stream into FX2 slave-FIFO writes,
// committing short packets with PKTEND after an idle timeout or on disable.
module fx2_stream_writer #(
  parameter int         PKT_WORDS = 256,
  parameter int         TIMEOUT   = 1024,
  parameter logic [1:0] EP_ADDR   = 2'b10
) (
  input  logic        STREAM_CLK,
  input  logic        STREAM_RST_N,
  input  logic        ENABLE,
  input  logic [15:0] DATA,
  input  logic        DATA_VALID,
  output logic        DATA_READY,
  input  logic [2:0]  USB_STREAM_FLAGS_N,
  input  logic        USB_STREAM_FX2Rdy,
  output logic [1:0]  USB_STREAM_FIFOADDR,
  output logic [15:0] USB_STREAM_DATA,
  output logic        USB_STREAM_SLWR_n,
  output logic        USB_STREAM_PKTEND_N,
  output logic        USB_STREAM_SLOE_n,
  output logic        USB_STREAM_SLRD_n,
  output logic [31:0] WORD_COUNT,
  output logic [8:0]  PKT_FILL
);
  localparam int IW = $clog2(TIMEOUT);
  localparam logic [8:0] PMAX = 9'(PKT_WORDS - 1);
  localparam logic [IW-1:0] TMAX = IW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, WRITE, FLUSH, GAP} state_t;
  state_t state, next;
  logic [8:0] pkt_cnt;
  logic [IW-1:0] idle_cnt;
  logic [31:0] word_cnt;
  logic nfull, accept, partial, flags_unused;
  assign nfull = USB_STREAM_FLAGS_N[1];
  assign flags_unused = ^{USB_STREAM_FLAGS_N[2], USB_STREAM_FLAGS_N[0]};
  assign partial = pkt_cnt != 9'd0;
  assign accept = (state == WRITE) && ENABLE && DATA_VALID && nfull && USB_STREAM_FX2Rdy;
  assign DATA_READY = accept;
  assign USB_STREAM_SLWR_n = ~accept;
  assign USB_STREAM_PKTEND_N = state != FLUSH;
  assign USB_STREAM_DATA = DATA;
  assign USB_STREAM_FIFOADDR = EP_ADDR;
  assign USB_STREAM_SLOE_n = 1'b1;
  assign USB_STREAM_SLRD_n = 1'b1;
  assign WORD_COUNT = word_cnt;
  assign PKT_FILL = pkt_cnt;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = (ENABLE && USB_STREAM_FX2Rdy && nfull) ? WRITE : IDLE;
      WRITE:   next = !ENABLE ? (partial ? FLUSH : IDLE)
                    : (idle_cnt == TMAX && nfull && partial && !accept) ? FLUSH : WRITE;
      FLUSH:   next = GAP;
      default: next = IDLE;
    endcase
  end
  // full packets auto-commit in the FX2, so pkt_cnt simply wraps
  always_ff @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
    if (!STREAM_RST_N) begin
      state    <= IDLE;
      pkt_cnt  <= 9'd0;
      idle_cnt <= '0;
      word_cnt <= 32'd0;
    end else begin
      state <= next;
      if (accept) begin
        pkt_cnt  <= (pkt_cnt == PMAX) ? 9'd0 : pkt_cnt + 9'd1;
        word_cnt <= word_cnt + 32'd1;
        idle_cnt <= '0;
      end else if (state == WRITE) begin
        idle_cnt <= !partial ? '0 : (idle_cnt == TMAX) ? idle_cnt : idle_cnt + IW'(1);
      end else if (state == FLUSH) begin
        pkt_cnt  <= 9'd0;
        idle_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fx2_stream_writer.sv
// tb_fx2_stream_writer: directed scenarios plus random traffic against a
// cycle-level packet/timeout reference model.
module tb_fx2_stream_writer;
  localparam int P = 4, T = 8;
  logic clk = 1'b0, rst_n, en, valid, fx2rdy;
  logic [15:0] din, dout;
  logic [2:0] flags;
  logic ready, slwr_n, pktend_n, sloe_n, slrd_n;
  logic [1:0] fifoaddr;
  logic [31:0] wcount;
  logic [8:0] fill;
  int n_cmp = 0, n_bad = 0;
  int mode, m_fill, quiet, left, slwr_lows, pktend_lows;
  logic [31:0] words;
  logic [15:0] nxt;
  always #5 clk = ~clk;
  fx2_stream_writer #(.PKT_WORDS(P), .TIMEOUT(T), .EP_ADDR(2'b10)) dut (
    .STREAM_CLK(clk), .STREAM_RST_N(rst_n), .ENABLE(en), .DATA(din),
    .DATA_VALID(valid), .DATA_READY(ready), .USB_STREAM_FLAGS_N(flags),
    .USB_STREAM_FX2Rdy(fx2rdy), .USB_STREAM_FIFOADDR(fifoaddr),
    .USB_STREAM_DATA(dout), .USB_STREAM_SLWR_n(slwr_n),
    .USB_STREAM_PKTEND_N(pktend_n), .USB_STREAM_SLOE_n(sloe_n),
    .USB_STREAM_SLRD_n(slrd_n), .WORD_COUNT(wcount), .PKT_FILL(fill)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic src();
    valid = left != 0;
    din = nxt;
  endtask
  task automatic clr();
    slwr_lows = 0;
    pktend_lows = 0;
  endtask
  // mode: 0 idle, 1 writing, 2 commit cycle, 3 recovery cycle
  task automatic step();
    logic a;
    int old;
    @(negedge clk);
    a = mode == 1 && en && valid && flags[1] && fx2rdy;
    chk("slwr_n", 32'(slwr_n), 32'(!a));
    chk("ready", 32'(ready), 32'(a));
    chk("pktend_n", 32'(pktend_n), 32'(mode != 2));
    chk("fill", 32'(fill), 32'(m_fill));
    chk("wcount", wcount, words);
    if (a) chk("data", 32'(dout), 32'(nxt));
    slwr_lows += int'(!slwr_n);
    pktend_lows += int'(!pktend_n);
    @(posedge clk);
    old = mode;
    case (mode)
      0: if (en && fx2rdy && flags[1]) mode = 1;
      1: if (!en) mode = (m_fill != 0) ? 2 : 0;
         else if (!a && m_fill != 0 && flags[1] && quiet >= T - 1) mode = 2;
      2: mode = 3;
      default: mode = 0;
    endcase
    if (a) begin
      words++;
      m_fill = (m_fill + 1) % P;
      quiet = 0;
      nxt++;
      left--;
    end else if (old == 1) quiet = (m_fill != 0) ? quiet + 1 : 0;
    else if (old == 2) begin
      m_fill = 0;
      quiet = 0;
    end
    #1 src();
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic reset();
    rst_n = 1'b0;
    en = 1'b1;
    fx2rdy = 1'b1;
    flags = 3'b111;
    left = 0;
    nxt = 16'd1;
    mode = 0;
    m_fill = 0;
    quiet = 0;
    words = 32'd0;
    src();
    clr();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    reset();
    chk("rst_slwr", 32'(slwr_n), 32'd1);
    chk("rst_pktend", 32'(pktend_n), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_wcount", wcount, 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("fifoaddr", 32'(fifoaddr), 32'd2);
    chk("sloe", 32'(sloe_n), 32'd1);
    chk("slrd", 32'(slrd_n), 32'd1);
    left = 8; src(); run(12);
    chk("burst_wcount", wcount, 32'd8);
    chk("burst_fill", 32'(fill), 32'd0);
    chk("burst_writes", 32'(slwr_lows), 32'd8);
    chk("burst_pktend", 32'(pktend_lows), 32'd0);
    reset(); left = 3; src(); run(5);
    chk("short_fill", 32'(fill), 32'd3);
    clr(); run(12);
    chk("timeout_pktend", 32'(pktend_lows), 32'd1);
    chk("timeout_fill", 32'(fill), 32'd0);
    chk("timeout_wcount", wcount, 32'd3);
    reset(); left = 2; src(); run(4);
    flags = 3'b101; clr(); run(20);
    chk("full_writes", 32'(slwr_lows), 32'd0);
    chk("full_pktend", 32'(pktend_lows), 32'd0);
    flags = 3'b111; clr(); run(2);
    chk("unfull_pktend", 32'(pktend_lows), 32'd1);
    reset(); left = 1; src(); run(9);
    left = 1; src(); clr(); run(1);
    chk("race_fill", 32'(fill), 32'd2);
    chk("race_pktend", 32'(pktend_lows), 32'd0);
    reset(); left = 2; src(); run(4);
    en = 1'b0; clr(); run(3);
    chk("disable_pktend", 32'(pktend_lows), 32'd1);
    en = 1'b1; left = 4; src(); run(8);
    en = 1'b0; clr(); run(3);
    chk("disable_empty_pktend", 32'(pktend_lows), 32'd0);
    chk("disable_empty_fill", 32'(fill), 32'd0);
    reset(); left = 4; src(); run(3);
    #2;
    chk("pre_rst_slwr", 32'(slwr_n), 32'd0);
    chk("pre_rst_fill", 32'(fill), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async_slwr", 32'(slwr_n), 32'd1);
    chk("async_pktend", 32'(pktend_n), 32'd1);
    chk("async_ready", 32'(ready), 32'd0);
    chk("async_wcount", wcount, 32'd0);
    chk("async_fill", 32'(fill), 32'd0);
    reset();
    repeat (3000) begin
      en = $urandom_range(0, 19) != 0;
      fx2rdy = $urandom_range(0, 9) != 0;
      flags = {1'b1, $urandom_range(0, 5) != 0, 1'b1};
      if (left == 0 && $urandom_range(0, 15) == 0) left = $urandom_range(1, 9);
      src();
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
